// File: rtl/axis_pkg.sv
// Shared definitions for the AXI Stream arbiter family: default widths and
// the source-index width helper.
package axis_pkg;

    localparam int DEFAULT_TDATA_WIDTH = 32;

    // Clamped so a degenerate one-requester build still gets a 1-bit index.
    function automatic int src_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI Stream bundle (tvalid/tdata/tready) with manager and
// subordinate views.
interface axis_if #(
    parameter int TDATA_WIDTH = 32
);
    logic                   tvalid;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tready;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/rr_grant.sv
// Round-robin grant generator: lowest requesting index at or above the
// pointer (wrapping), pointer moves past the winner on each update strobe.
module rr_grant
    import axis_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SRC_WIDTH = src_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 update,
    output logic [NUM_REQ-1:0]   grant,
    output logic [SRC_WIDTH-1:0] grant_idx
);

    logic [SRC_WIDTH-1:0] ptr;
    logic                 found;

    // Two passes give the wrap: indices >= ptr first, then the ones below it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = SRC_WIDTH'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j < int'(ptr))) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = SRC_WIDTH'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (update) begin
            ptr <= (grant_idx == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI Stream round-robin arbiter with a registered output and a
// one-entry skid, so s_tready never depends combinationally on tready.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TDATA_WIDTH = DEFAULT_TDATA_WIDTH,
    parameter int SRC_WIDTH   = src_width(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             s_tvalid,
    input  logic [NUM_REQ*TDATA_WIDTH-1:0] s_tdata,
    output logic [NUM_REQ-1:0]             s_tready,
    axis_if.m                              axis_mif,
    output logic [SRC_WIDTH-1:0]           m_tsrc,
    input  logic                           invalidate
);

    if (TDATA_WIDTH <= 0) begin : g_bad_width
        $fatal(1, "axis_rr_arbiter: TDATA_WIDTH must be > 0");
    end
    if ($bits(axis_mif.tdata) != TDATA_WIDTH) begin : g_width_mismatch
        $fatal(1, "axis_rr_arbiter: TDATA_WIDTH differs from axis_mif tdata width");
    end

    typedef struct packed {
        logic                   valid;
        logic [TDATA_WIDTH-1:0] data;
        logic [SRC_WIDTH-1:0]   src;
    } entry_t;

    entry_t                 out_q, out_d;
    entry_t                 skid_q, skid_d;
    entry_t                 new_beat;
    logic                   accept_q;
    logic                   hs;
    logic                   out_load;
    logic [NUM_REQ-1:0]     grant;
    logic [SRC_WIDTH-1:0]   grant_idx;
    logic [TDATA_WIDTH-1:0] new_data;

    rr_grant #(
        .NUM_REQ   (NUM_REQ),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_grant (
        .clk       (clk),
        .rst       (rst),
        .req       (s_tvalid),
        .update    (hs),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A beat moves on a side when valid and ready are both high at a posedge;
    // valid never waits for ready, and a presented beat holds until taken.
    assign s_tready = accept_q ? grant : '0;
    assign hs       = accept_q && (|s_tvalid);
    assign out_load = !out_q.valid || axis_mif.tready;

    always_comb begin
        new_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) new_data = s_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
        end
        new_beat.valid = 1'b1;
        new_beat.data  = new_data;
        new_beat.src   = grant_idx;
    end

    // The skid holds the older beat, so it drains first to keep grant order.
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (out_load) begin
            if (skid_q.valid) begin
                out_d        = skid_q;
                skid_d.valid = 1'b0;
                if (hs) skid_d = new_beat;
            end else if (hs) begin
                out_d = new_beat;
            end else begin
                out_d.valid = 1'b0;
            end
        end else if (hs) begin
            skid_d = new_beat;
        end
        if (invalidate) begin
            out_d.valid  = 1'b0;
            skid_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            skid_q   <= '0;
            accept_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            skid_q   <= skid_d;
            accept_q <= !skid_d.valid;
        end
    end

    assign axis_mif.tvalid = out_q.valid;
    assign axis_mif.tdata  = out_q.data;
    assign m_tsrc          = out_q.src;

endmodule
